// File: rtl/fifo_wr_ctrl.sv
// Write-domain half of the async FIFO: binary/Gray write pointer, full and
// almost-full flags, fill-level estimate and sticky overflow.
module fifo_wr_ctrl #(
    parameter int P_SIZE   = 4,
    parameter int AF_LEVEL = 6
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_inc,
    input  logic              ovf_clr,
    input  logic [P_SIZE-1:0] sync_rd_ptr,
    output logic              wr_en,
    output logic [P_SIZE-2:0] wr_addr,
    output logic [P_SIZE-1:0] wr_ptr,
    output logic              full,
    output logic              almost_full,
    output logic [P_SIZE-1:0] wr_level,
    output logic              overflow
);

    localparam logic [P_SIZE-1:0] AF_THR = P_SIZE'(AF_LEVEL);

    logic [P_SIZE-1:0] wr_bin_q, wr_bin_d;
    logic [P_SIZE-1:0] wr_ptr_q, wr_gray_d;
    logic [P_SIZE-1:0] rd_bin;
    logic [P_SIZE-1:0] level_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic [P_SIZE-1:0] level_q;
    logic              ovf_q, ovf_d;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i < P_SIZE; i++) begin
            rd_bin[i] = ^(sync_rd_ptr >> i);
        end
    end

    always_comb begin
        wr_bin_d  = (w_inc && !full_q) ? wr_bin_q + 1'b1 : wr_bin_q;
        wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
        // Full when write pointer is exactly one lap ahead of the read pointer.
        full_d    = (wr_gray_d == {~sync_rd_ptr[P_SIZE-1:P_SIZE-2],
                                   sync_rd_ptr[P_SIZE-3:0]});
        level_d   = wr_bin_d - rd_bin;
        af_d      = (level_d >= AF_THR);
        if (w_inc && full_q)
            ovf_d = 1'b1;
        else if (ovf_clr)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wr_bin_q <= '0;
            wr_ptr_q <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_bin_q <= wr_bin_d;
            wr_ptr_q <= wr_gray_d;
            full_q   <= full_d;
            af_q     <= af_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_en       = w_inc & ~full_q;
    assign wr_addr     = wr_bin_q[P_SIZE-2:0];
    assign wr_ptr      = wr_ptr_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-domain controller of the asynchronous FIFO; counterpart of the read-side pointer logic. Maintains the binary write address and Gray-coded write pointer, and raises registered full/almost-full flags by comparing against the read pointer synchronized into the write domain. Also produces a fill-level estimate and a sticky overflow flag. Sits between the upstream producer, the dual-port FIFO memory write port, and the write→read pointer synchronizer.

## Interface
- P_SIZE, 4, pointer width; FIFO depth = 2^(P_SIZE-1) (default 8)
- AF_LEVEL, 6, almost-full threshold in entries (1..depth)
- w_clk  in  1  write-domain clock
- w_rst  in  1  asynchronous, active-high reset
- w_inc  in  1  producer write request
- ovf_clr  in  1  clears sticky overflow
- sync_rd_ptr  in  P_SIZE  Gray-coded read pointer, already 2-flop synchronized into w_clk
- wr_en  out  1  memory write enable = w_inc & ~full (combinational)
- wr_addr  out  P_SIZE-1  binary write address = wr_bin[P_SIZE-2:0]
- wr_ptr  out  P_SIZE  registered Gray-coded write pointer, to synchronizer
- full  out  1  registered FIFO full flag
- almost_full  out  1  registered, wr_level >= AF_LEVEL
- wr_level  out  P_SIZE  registered fill level as seen from write domain (0..depth)
- overflow  out  1  sticky: write attempted while full

## Operation
- Internal registers: wr_bin (P_SIZE binary), wr_ptr (Gray), full, almost_full, wr_level, overflow.
- Reset (w_rst high, async): wr_bin=0, wr_ptr=0, full=0, almost_full=0, wr_level=0, overflow=0. wr_en is 0 while w_inc=0.
- Accept: write accepted on w_clk rising edge iff w_inc=1 and full=0. Then wr_bin_next = wr_bin+1 (mod 2^P_SIZE), otherwise wr_bin_next = wr_bin.
- Gray: wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1); wr_ptr <= wr_gray_next. Only one bit of wr_ptr changes per accepted write.
- Full: full <= (wr_gray_next == {~sync_rd_ptr[P_SIZE-1:P_SIZE-2], sync_rd_ptr[P_SIZE-3:0]}). Computed from next pointer so full asserts on the same edge as the write that fills the FIFO.
- Level: rd_bin = Gray-to-binary(sync_rd_ptr); wr_level <= (wr_bin_next - rd_bin) mod 2^P_SIZE. almost_full <= (that value >= AF_LEVEL).
- Overflow: on edge with w_inc=1 and full=1, overflow <= 1; wr_bin/wr_ptr unchanged, no memory write. ovf_clr=1 clears overflow; if overflow condition and ovf_clr coincide, set wins.
- Flags are pessimistic: full/almost_full/wr_level lag reads by the synchronizer latency; never indicate fewer entries than actually present.

## Timing
- wr_en: same-cycle combinational from w_inc and registered full; no path from sync_rd_ptr.
- Write-to-flag latency: 1 w_clk (flags updated on the accepting edge).
- Read-to-flag latency: 1 w_clk after sync_rd_ptr changes (plus external 2-flop synchronizer, i.e. ≥3 w_clk after read-side pointer update).
- Wrap-around: wr_bin rolls 2^P_SIZE-1 → 0; MSB toggles each pass through depth, distinguishing full from empty.
- Simultaneous write and sync_rd_ptr change on same edge: both used; level = new wr_bin minus new rd_bin, full evaluated against new sync_rd_ptr.
- Write while full and read pointer advancing same edge: write rejected (full was 1 at edge); full may drop next cycle.
- Reset mid-operation: all registers clear immediately (async); overflow lost; wr_ptr returns to 0 (read side must be reset together).

## Test plan
- Reset: assert w_rst mid-burst asynchronously -> wr_ptr=0, wr_addr=0, full=0, wr_level=0, overflow=0 without waiting for w_clk.
- Fill: sync_rd_ptr=0, 8 consecutive w_inc -> wr_addr 0..7, wr_ptr Gray 0,1,3,2,6,7,5,4 then 4'b1100; full=1 after 8th edge, almost_full=1 after 6th, wr_level=8.
- Overflow: full, w_inc held 2 cycles -> wr_en=0, wr_ptr stays 4'b1100, overflow=1 sticky; ovf_clr pulse -> 0; ovf_clr with concurrent overflow -> stays 1.
- Drain release: from full, drive sync_rd_ptr 4'b0001 -> full=0 and wr_level=7 one cycle later; next w_inc accepted, wr_addr=0.
- Wrap: 20 writes interleaved with reads (sync_rd_ptr tracking with 3-cycle lag) -> wr_addr wraps 7→0, wr_ptr MSB toggles at 8 and 16, no false full, wr_level never below true occupancy.
- Simultaneous: full with w_inc=1 on the edge sync_rd_ptr advances -> write rejected, full deasserts next cycle, write accepted the cycle after.
